// File: rtl/lsu_mem_bridge_if.sv
// Request/response handshakes plus the simulation memory port of the LSU bridge.
interface lsu_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;

  // The LSU and memory model side of the bridge.
  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );
endinterface

// File: rtl/lsu_mem_bridge.sv
// One-at-a-time load/store bridge: alignment check, modelled latency,
// single-cycle memory strobe, load extension and a buffered response.
module lsu_mem_bridge #(
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] RESET_ADDR = 64'h8000_0000
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic [63:0] rd_addr_q;
  logic [63:0] we_addr_q;
  logic [63:0] we_data_q;
  logic [7:0]  we_mask_q;
  logic        accept;
  logic        misaligned;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic sgn);
    logic [63:0] r;
    case (sz)
      2'd0:    r = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      2'd1:    r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      2'd2:    r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      2'd3:    misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign bus.req_ready = (state == IDLE) && rst;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)      next_state = RESP;
          else if (LATENCY > 0) next_state = WAIT;
          else                 next_state = ACCESS;
        end
      end
      WAIT:    if (cnt == 4'd0) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from state so an asynchronous reset drops them at once.
  assign bus.mem_rd_en   = (state == ACCESS) && !wr_q;
  assign bus.mem_we_en   = (state == ACCESS) && wr_q;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.mem_we_addr = we_addr_q;
  assign bus.mem_we_data = we_data_q;
  assign bus.mem_we_mask = we_mask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      rd_addr_q    <= RESET_ADDR;
      we_addr_q    <= 64'd0;
      we_data_q    <= 64'd0;
      we_mask_q    <= 8'h00;
    end else begin
      state <= next_state;
      if (accept) begin
        wr_q         <= bus.req_write;
        size_q       <= bus.req_size;
        signed_q     <= bus.req_signed;
        resp_rdata_q <= 64'd0;
        resp_err_q   <= misaligned;
        cnt          <= WAIT_LOAD;
        // Memory-facing registers move only for aligned requests of their own kind.
        if (!misaligned) begin
          if (bus.req_write) begin
            we_addr_q <= bus.req_addr;
            we_mask_q <= size_mask(bus.req_size);
            we_data_q <= bus.req_wdata & extend({64{1'b1}}, bus.req_size, 1'b0);
          end else begin
            rd_addr_q <= bus.req_addr;
          end
        end
      end
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == ACCESS && !wr_q) resp_rdata_q <= extend(bus.mem_rd_data, size_q, signed_q);
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: vector table of single transactions plus
// reset, back-pressure and reset-during-wait sequences.
module tb_lsu_mem_bridge;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lsu_mem_bridge_if bus ();
  lsu_mem_bridge_if bus3 ();

  lsu_mem_bridge #(.LATENCY(LAT), .RESET_ADDR(64'h8000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  lsu_mem_bridge #(.LATENCY(3), .RESET_ADDR(64'h8000_0000)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    logic [63:0] mdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int          strobe_k = -1;
    int          strobes = 0;
    int          resp_k = -1;
    int          both = 0;
    bit          got = 0;
    logic [63:0] rd_addr_before = bus.mem_rd_addr;
    logic [63:0] we_addr_before = bus.mem_we_addr;
    logic [63:0] we_data_before = bus.mem_we_data;
    logic [7:0]  we_mask_before = bus.mem_we_mask;
    logic [63:0] seen_addr = 64'd0;
    logic [63:0] seen_data = 64'd0;
    logic [7:0]  seen_mask = 8'd0;
    logic [63:0] rdata = 64'd0;
    logic        err = 1'b0;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = v.write;
    bus.req_addr    = v.addr;
    bus.req_size    = v.size;
    bus.req_signed  = v.sgn;
    bus.req_wdata   = v.wdata;
    bus.mem_rd_data = v.mdata;
    bus.resp_ready  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready) got = 1;
      else @(negedge clk);
    end
    checkOutput($sformatf("v%0d_accept", idx), 64'(got), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en && bus.mem_we_en) both++;
      if (bus.mem_rd_en || bus.mem_we_en) begin
        strobes++;
        strobe_k  = k;
        seen_addr = v.write ? bus.mem_we_addr : bus.mem_rd_addr;
        seen_data = bus.mem_we_data;
        seen_mask = bus.mem_we_mask;
      end
      if (bus.resp_valid) begin
        resp_k = k;
        rdata  = bus.resp_rdata;
        err    = bus.resp_err;
        break;
      end
    end
    checkOutput($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
    checkOutput($sformatf("v%0d_both_strobes", idx), 64'(both), 64'd0);
    if (v.exp_err) begin
      checkOutput($sformatf("v%0d_resp_k", idx), 64'(resp_k), 64'd0);
      checkOutput($sformatf("v%0d_strobes", idx), 64'(strobes), 64'd0);
      checkOutput($sformatf("v%0d_rd_addr_hold", idx), bus.mem_rd_addr, rd_addr_before);
      checkOutput($sformatf("v%0d_we_addr_hold", idx), bus.mem_we_addr, we_addr_before);
      checkOutput($sformatf("v%0d_we_data_hold", idx), bus.mem_we_data, we_data_before);
      checkOutput($sformatf("v%0d_we_mask_hold", idx), 64'(bus.mem_we_mask), 64'(we_mask_before));
    end else begin
      checkOutput($sformatf("v%0d_resp_k", idx), 64'(resp_k), 64'(LAT + 1));
      checkOutput($sformatf("v%0d_strobes", idx), 64'(strobes), 64'd1);
      checkOutput($sformatf("v%0d_strobe_k", idx), 64'(strobe_k), 64'(LAT));
      checkOutput($sformatf("v%0d_mem_addr", idx), seen_addr, v.addr);
      if (v.write) begin
        checkOutput($sformatf("v%0d_we_mask", idx), 64'(seen_mask), 64'(v.exp_mask));
        checkOutput($sformatf("v%0d_we_data", idx), seen_data, v.exp_wdata);
        checkOutput($sformatf("v%0d_rd_addr_hold", idx), bus.mem_rd_addr, rd_addr_before);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready_after", idx), 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_wdata = 64'h0; bus.resp_ready = 1'b1; bus.mem_rd_data = 64'h0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = 64'h0; bus3.req_size = 2'd0;
    bus3.req_signed = 1'b0; bus3.req_wdata = 64'h0; bus3.resp_ready = 1'b1; bus3.mem_rd_data = 64'h0;

    //         wr   addr                  sz    sgn  wdata                  mdata                  exp_rdata              err  mask   exp_wdata
    vecs[0]  = '{1'b1, 64'h0000_0000_8000_0010, 2'd2, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'h0,                  64'h0,                  1'b0, 8'h0F, 64'h0000_0000_1234_5678};
    vecs[1]  = '{1'b0, 64'h0000_0000_8000_0021, 2'd0, 1'b1, 64'h0,                  64'h1122_3344_5566_7780, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 8'h00, 64'h0};
    vecs[2]  = '{1'b0, 64'h0000_0000_8000_0021, 2'd0, 1'b0, 64'h0,                  64'h1122_3344_5566_7780, 64'h0000_0000_0000_0080, 1'b0, 8'h00, 64'h0};
    vecs[3]  = '{1'b0, 64'h0000_0000_8000_0002, 2'd1, 1'b1, 64'h0,                  64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 8'h00, 64'h0};
    vecs[4]  = '{1'b0, 64'h0000_0000_8000_0004, 2'd2, 1'b0, 64'h0,                  64'hAAAA_BBBB_F000_0001, 64'h0000_0000_F000_0001, 1'b0, 8'h00, 64'h0};
    vecs[5]  = '{1'b0, 64'h0000_0000_8000_0004, 2'd2, 1'b1, 64'h0,                  64'hAAAA_BBBB_F000_0001, 64'hFFFF_FFFF_F000_0001, 1'b0, 8'h00, 64'h0};
    vecs[6]  = '{1'b0, 64'h0000_0000_8000_0008, 2'd3, 1'b1, 64'h0,                  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 8'h00, 64'h0};
    vecs[7]  = '{1'b1, 64'h0000_0000_8000_0003, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                  64'h0,                  1'b0, 8'h01, 64'h0000_0000_0000_00AB};
    vecs[8]  = '{1'b1, 64'h0000_0000_8000_0006, 2'd1, 1'b0, 64'h1111_2222_3333_C0DE, 64'h0,                  64'h0,                  1'b0, 8'h03, 64'h0000_0000_0000_C0DE};
    vecs[9]  = '{1'b1, 64'h0000_0000_8000_0018, 2'd3, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 64'h0,                  64'h0,                  1'b0, 8'hFF, 64'h0F0E_0D0C_0B0A_0908};
    vecs[10] = '{1'b0, 64'h0000_0000_8000_0004, 2'd3, 1'b0, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1, 8'h00, 64'h0};
    vecs[11] = '{1'b1, 64'h0000_0000_8000_0001, 2'd1, 1'b0, 64'h5555_5555_5555_5555, 64'h0,                  64'h0,                  1'b1, 8'h00, 64'h0};
    vecs[12] = '{1'b0, 64'h0000_0000_8000_0042, 2'd2, 1'b1, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1, 8'h00, 64'h0};

    // Reset held with a request pending: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      checkOutput($sformatf("rst%0d_strobes", i), 64'({bus.mem_rd_en, bus.mem_we_en}), 64'd0);
      checkOutput($sformatf("rst%0d_resp_valid", i), 64'(bus.resp_valid), 64'd0);
    end
    checkOutput("rst_rd_addr", bus.mem_rd_addr, 64'h8000_0000);
    checkOutput("rst_we_addr", bus.mem_we_addr, 64'd0);
    checkOutput("rst_we_mask", 64'(bus.mem_we_mask), 64'd0);
    checkOutput("rst_resp", {bus.resp_rdata[62:0], bus.resp_err}, 64'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Back-pressure: response must hold steady and block new requests.
    begin
      bit got = 0;
      int stable_bad = 0;
      int strobe_seen = 0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h8000_0040;
      bus.req_size = 2'd1; bus.req_signed = 1'b0; bus.mem_rd_data = 64'h1234_5678_9ABC_BEEF;
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (bus.resp_valid) got = 1;
      end
      checkOutput("bp_resp_seen", 64'(got), 64'd1);
      checkOutput("bp_rdata", bus.resp_rdata, 64'h0000_0000_0000_BEEF);
      bus.req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (!bus.resp_valid || bus.resp_rdata !== 64'hBEEF || bus.resp_err || bus.req_ready)
          stable_bad++;
        if (bus.mem_rd_en || bus.mem_we_en) strobe_seen++;
      end
      checkOutput("bp_hold", 64'(stable_bad), 64'd0);
      checkOutput("bp_no_strobe", 64'(strobe_seen), 64'd0);
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_ready_after", 64'(bus.req_ready), 64'd1);
      checkOutput("bp_valid_after", 64'(bus.resp_valid), 64'd0);
    end

    // Reset during WAIT on the LATENCY=3 instance: request must vanish.
    begin
      int activity = 0;
      int not_ready = 0;
      @(negedge clk);
      bus3.req_valid = 1'b1; bus3.req_write = 1'b1; bus3.req_addr = 64'h8000_0100;
      bus3.req_size = 2'd3; bus3.req_wdata = 64'hCAFE_F00D_0000_1111;
      checkOutput("rw_ready", 64'(bus3.req_ready), 64'd1);
      @(posedge clk);
      #1 bus3.req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rw_in_reset", 64'({bus3.req_ready, bus3.resp_valid, bus3.mem_we_en}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus3.mem_we_en || bus3.mem_rd_en || bus3.resp_valid) activity++;
        if (!bus3.req_ready) not_ready++;
      end
      checkOutput("rw_no_activity", 64'(activity), 64'd0);
      checkOutput("rw_idle", 64'(not_ready), 64'd0);
      checkOutput("rw_we_mask_cleared", 64'(bus3.mem_we_mask), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
